// File: rtl/xs3_digit_accumulator.sv
// Folds a most-significant-first stream of decimal digits into one binary word
// (acc = acc*10 + digit) and hands the result off on a valid/ready port.
module xs3_digit_accumulator #(
   parameter int NDIG  = 4,
   parameter int OUT_W = 14,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_digit,
   input  logic             in_code_ok,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_value,
   output logic             out_err,
   output logic [CNT_W-1:0] out_ndig
);

   localparam logic [0:0] ST_ACC = 1'b0;
   localparam logic [0:0] ST_OUT = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NDIG);

   logic [0:0]       state;
   logic [OUT_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             err;

   logic             accept;
   logic             bad;
   logic             err_nxt;
   logic [OUT_W+3:0] prod;
   logic [OUT_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   assign in_ready = (state == ST_ACC);
   assign accept   = in_valid & in_ready;

   // A beat past the NDIG limit is bad even if its code and digit are fine.
   assign bad      = ~in_code_ok | (in_digit > 4'd9) | (cnt == CNT_MAX);
   assign err_nxt  = err | bad;
   assign prod     = {4'b0000, acc} * (OUT_W+4)'(10) + (OUT_W+4)'(in_digit);
   assign acc_nxt  = err_nxt ? acc : prod[OUT_W-1:0];
   assign cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ACC;
         acc       <= '0;
         cnt       <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_value <= '0;
         out_err   <= 1'b0;
         out_ndig  <= '0;
      end else begin
         case (state)
            ST_ACC: begin
               if (accept) begin
                  acc <= acc_nxt;
                  cnt <= cnt_nxt;
                  err <= err_nxt;
                  if (in_last) begin
                     state     <= ST_OUT;
                     out_valid <= 1'b1;
                     out_value <= err_nxt ? '0 : acc_nxt;
                     out_err   <= err_nxt;
                     out_ndig  <= cnt_nxt;
                  end
               end
            end
            default: begin
               // Frame state is cleared on handoff; out_* keep the last result.
               if (out_ready) begin
                  state     <= ST_ACC;
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  err       <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xs3_digit_accumulator.sv
// Directed and randomized frames checked against a digit-list reference model.
module tb_xs3_digit_accumulator;

   localparam int NDIG  = 4;
   localparam int OUT_W = 14;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_digit;
   logic             in_code_ok;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_value;
   logic             out_err;
   logic [CNT_W-1:0] out_ndig;

   int n_cmp = 0;
   int n_bad = 0;
   int q_dig[$];
   int q_ok[$];

   always #5 clk = ~clk;

   xs3_digit_accumulator #(.NDIG(NDIG), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
      .in_code_ok(in_code_ok), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
      .out_err(out_err), .out_ndig(out_ndig)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input int d, input int ok, input bit last);
      in_valid   = 1'b1;
      in_digit   = 4'(d);
      in_code_ok = ok[0];
      in_last    = last;
      @(posedge clk); #1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
   endtask

   // Plays q_dig/q_ok as one frame, holds the result for 'hold' cycles, then hands off.
   task automatic frame(input string tag, input int hold);
      int  n;
      bit  e;
      longint v;
      int  nd;
      n = q_dig.size();
      e = 1'b0;
      v = 0;
      for (int i = 0; i < n; i++) begin
         if (q_ok[i] == 0 || q_dig[i] > 9 || i >= NDIG) e = 1'b1;
         else if (!e) v = v * 10 + q_dig[i];
      end
      nd = (n > NDIG) ? NDIG : n;
      out_ready = (hold == 0);
      for (int i = 0; i < n; i++) begin
         chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
         beat(q_dig[i], q_ok[i], i == n - 1);
      end
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".value"}, 32'(out_value), e ? 32'd0 : 32'(v));
      chk({tag, ".err"}, 32'(out_err), 32'(e));
      chk({tag, ".ndig"}, 32'(out_ndig), 32'(nd));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1; in_digit = 4'($urandom_range(0, 15));
         in_code_ok = 1'b1; in_last = 1'b1;
         @(posedge clk); #1;
         chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
         chk({tag, ".hold_value"}, 32'(out_value), e ? 32'd0 : 32'(v));
         chk({tag, ".hold_ndig"}, 32'(out_ndig), 32'(nd));
      end
      in_valid = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, ".post_ready"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      q_dig.delete();
      q_ok.delete();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_digit = '0; in_code_ok = 1'b0;
      in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.value", 32'(out_value), 32'd0);
      chk("rst.err", 32'(out_err), 32'd0);
      chk("rst.ndig", 32'(out_ndig), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      q_dig = '{1, 2, 3, 4};       q_ok = '{1, 1, 1, 1};       frame("t1", 0);
      q_dig = '{7};                q_ok = '{1};                frame("t2", 5);
      q_dig = '{5, 3, 9};          q_ok = '{1, 0, 1};          frame("t3", 0);
      q_dig = '{9, 9, 9, 9, 9, 9}; q_ok = '{1, 1, 1, 1, 1, 1}; frame("t4a", 1);
      q_dig = '{9, 9, 9, 9};       q_ok = '{1, 1, 1, 1};       frame("t4b", 0);
      q_dig = '{2, 11, 3};         q_ok = '{1, 1, 1};          frame("t5a", 0);
      q_dig = '{0, 0, 4};          q_ok = '{1, 1, 1};          frame("t5b", 0);

      // Reset mid-frame discards the partial frame.
      beat(8, 1, 1'b0);
      beat(6, 1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6.rst_valid", 32'(out_valid), 32'd0);
      chk("t6.rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      q_dig = '{3}; q_ok = '{1}; frame("t6a", 0);

      // Async reset while a result is pending drops out_valid without a clock edge.
      out_ready = 1'b0;
      beat(5, 1, 1'b1);
      chk("t6b.valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6b.async_valid", 32'(out_valid), 32'd0);
      chk("t6b.async_value", 32'(out_value), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            int r;
            r = $urandom_range(0, 19);
            q_dig.push_back((r == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            q_ok.push_back((r == 1) ? 0 : 1);
         end
         frame("rnd", $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
